// File: rtl/word_adder_pkg.sv
// Shared command encoding and limits for the word adder chain.
package word_adder_pkg;

   typedef enum logic [1:0] {
      FUNC_IDLE = 2'd0,
      FUNC_LOAD = 2'd1,
      FUNC_ACC  = 2'd2,
      FUNC_CLR  = 2'd3
   } func_e;

   localparam int STAGES_MAX = 8;

endpackage

// File: rtl/word_adder_stage.sv
// One accumulator stage: adds its upstream value on enable, wraps or clamps on carry out.
module word_adder_stage #(
   parameter int WIDTH    = 9,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             enable,
   input  logic [WIDTH-1:0] addend,
   output logic [WIDTH-1:0] acc,
   output logic             carry
);

   logic [WIDTH:0] sum;

   assign sum = {1'b0, acc} + {1'b0, addend};

   // Combinational pulse so the sticky flag updates on the same edge as the accumulator.
   assign carry = enable & sum[WIDTH];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc <= '0;
      end else if (enable) begin
         if (SATURATE && sum[WIDTH]) acc <= '1;
         else                        acc <= sum[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/word_adder_chain.sv
// Word register feeding a chain of accumulator stages, with fill tracking and sticky overflow.
module word_adder_chain
   import word_adder_pkg::*;
#(
   parameter int WIDTH    = 9,
   parameter int STAGES   = 2,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       func,
   input  logic [WIDTH-1:0] inWord,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             overflow
);

   localparam int CNT_W = $clog2(STAGES + 1);

   func_e            cmd;
   logic             load_cmd;
   logic             acc_cmd;
   logic             clr_cmd;
   logic [WIDTH-1:0] word;
   logic [CNT_W-1:0] fill_cnt;
   logic             ovf;
   logic [WIDTH-1:0] acc [STAGES];
   logic [STAGES-1:0] carry;

   assign cmd      = func_e'(func);
   assign load_cmd = (cmd == FUNC_LOAD);
   assign acc_cmd  = (cmd == FUNC_ACC);
   assign clr_cmd  = (cmd == FUNC_CLR);

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      logic [WIDTH-1:0] addend;

      if (g == 0) begin : g_first
         assign addend = word;
      end else begin : g_chain
         assign addend = acc[g-1];
      end

      word_adder_stage #(
         .WIDTH    (WIDTH),
         .SATURATE (SATURATE)
      ) u_stage (
         .clk    (clk),
         .rst    (rst),
         .clr    (clr_cmd),
         .enable (acc_cmd),
         .addend (addend),
         .acc    (acc[g]),
         .carry  (carry[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word <= '0;
      end else if (load_cmd) begin
         word <= inWord;
      end
   end

   // A load restarts the fill count but leaves partially filled accumulators alone.
   always_ff @(posedge clk) begin
      if (rst || clr_cmd || load_cmd) begin
         fill_cnt <= '0;
      end else if (acc_cmd && (fill_cnt != CNT_W'(STAGES))) begin
         fill_cnt <= fill_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr_cmd) begin
         ovf <= 1'b0;
      end else if (|carry) begin
         ovf <= 1'b1;
      end
   end

   assign result       = acc[STAGES-1];
   assign result_valid = (fill_cnt == CNT_W'(STAGES));
   assign overflow     = ovf;

endmodule

// File: tb/tb_word_adder_chain.sv
// Directed bench driving four parameterisations of the chain from one shared stimulus.
module tb_word_adder_chain;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] func;
   logic [8:0] inWord;

   logic [8:0] d2_result, d1_result, ds_result, d3_result;
   logic       d2_valid, d1_valid, ds_valid, d3_valid;
   logic       d2_ovf, d1_ovf, ds_ovf, d3_ovf;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   word_adder_chain #(.WIDTH(9), .STAGES(2), .SATURATE(0)) dut2 (
      .clk(clk), .rst(rst), .func(func), .inWord(inWord),
      .result(d2_result), .result_valid(d2_valid), .overflow(d2_ovf));

   word_adder_chain #(.WIDTH(9), .STAGES(1), .SATURATE(0)) dut1 (
      .clk(clk), .rst(rst), .func(func), .inWord(inWord),
      .result(d1_result), .result_valid(d1_valid), .overflow(d1_ovf));

   word_adder_chain #(.WIDTH(9), .STAGES(2), .SATURATE(1)) dut_sat (
      .clk(clk), .rst(rst), .func(func), .inWord(inWord),
      .result(ds_result), .result_valid(ds_valid), .overflow(ds_ovf));

   word_adder_chain #(.WIDTH(9), .STAGES(3), .SATURATE(0)) dut3 (
      .clk(clk), .rst(rst), .func(func), .inWord(inWord),
      .result(d3_result), .result_valid(d3_valid), .overflow(d3_ovf));

   task automatic step(input logic [1:0] f, input logic [8:0] w);
      @(negedge clk);
      func   = f;
      inWord = w;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(2'd2, 9'h1FF);
      step(2'd2, 9'h1FF);
      checks++; if (d2_result !== 9'd0) begin failures++; $display("FAIL reset_result got=%h exp=000", d2_result); end
      checks++; if (d2_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", d2_valid); end
      checks++; if (d2_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", d2_ovf); end
      checks++; if (d1_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_s1 got=%b exp=0", d1_valid); end
      rst = 1'b0;
      step(2'd0, 9'h000);
      checks++; if (d2_result !== 9'd0) begin failures++; $display("FAIL reset_post_result got=%h exp=000", d2_result); end
   endtask

   task automatic test_fill();
      step(2'd1, 9'd5);
      step(2'd2, 9'h0AA);
      checks++; if (d2_result !== 9'd0 || d2_valid !== 1'b0) begin failures++; $display("FAIL fill1 got=%h/%b exp=000/0", d2_result, d2_valid); end
      checks++; if (d1_result !== 9'd5 || d1_valid !== 1'b1) begin failures++; $display("FAIL fill1_s1 got=%h/%b exp=005/1", d1_result, d1_valid); end
      step(2'd2, 9'h0AA);
      checks++; if (d2_result !== 9'd5 || d2_valid !== 1'b1) begin failures++; $display("FAIL fill2 got=%h/%b exp=005/1", d2_result, d2_valid); end
      checks++; if (d3_valid !== 1'b0) begin failures++; $display("FAIL fill2_s3_valid got=%b exp=0", d3_valid); end
      step(2'd2, 9'h0AA);
      checks++; if (d2_result !== 9'd15 || d2_valid !== 1'b1) begin failures++; $display("FAIL fill3 got=%h/%b exp=00f/1", d2_result, d2_valid); end
      checks++; if (d3_result !== 9'd5 || d3_valid !== 1'b1) begin failures++; $display("FAIL fill3_s3 got=%h/%b exp=005/1", d3_result, d3_valid); end
      checks++; if (d1_result !== 9'd15) begin failures++; $display("FAIL fill3_s1 got=%h exp=00f", d1_result); end
      for (int i = 0; i < 3; i++) step(2'd0, 9'h1FF);
      checks++; if (d2_result !== 9'd15 || d2_valid !== 1'b1 || d2_ovf !== 1'b0) begin failures++; $display("FAIL fill_idle got=%h/%b/%b exp=00f/1/0", d2_result, d2_valid, d2_ovf); end
   endtask

   task automatic test_clear();
      step(2'd3, 9'h1FF);
      checks++; if (d2_result !== 9'd0 || d2_valid !== 1'b0 || d2_ovf !== 1'b0) begin failures++; $display("FAIL clear got=%h/%b/%b exp=000/0/0", d2_result, d2_valid, d2_ovf); end
      step(2'd2, 9'h1FF);
      checks++; if (d1_result !== 9'd5) begin failures++; $display("FAIL clear_acc0 got=%h exp=005", d1_result); end
      checks++; if (d2_result !== 9'd0 || d2_valid !== 1'b0) begin failures++; $display("FAIL clear_acc_last got=%h/%b exp=000/0", d2_result, d2_valid); end
   endtask

   task automatic test_overflow();
      step(2'd3, 9'h000);
      step(2'd1, 9'h1FF);
      step(2'd2, 9'h000);
      checks++; if (d2_ovf !== 1'b0 || d1_result !== 9'h1FF) begin failures++; $display("FAIL ovf_first got=%b/%h exp=0/1ff", d2_ovf, d1_result); end
      step(2'd2, 9'h000);
      checks++; if (d1_result !== 9'h1FE || d1_ovf !== 1'b1) begin failures++; $display("FAIL wrap_acc0 got=%h/%b exp=1fe/1", d1_result, d1_ovf); end
      checks++; if (d2_result !== 9'h1FF || d2_ovf !== 1'b1) begin failures++; $display("FAIL wrap_last got=%h/%b exp=1ff/1", d2_result, d2_ovf); end
      for (int i = 0; i < 5; i++) step(2'd0, 9'h000);
      checks++; if (d2_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", d2_ovf); end
      step(2'd2, 9'h000);
      checks++; if (d2_result !== 9'h1FD) begin failures++; $display("FAIL wrap3 got=%h exp=1fd", d2_result); end
      checks++; if (ds_result !== 9'h1FF || ds_ovf !== 1'b1) begin failures++; $display("FAIL sat3 got=%h/%b exp=1ff/1", ds_result, ds_ovf); end
      checks++; if (dut_sat.acc[0] !== 9'h1FF) begin failures++; $display("FAIL sat_acc0 got=%h exp=1ff", dut_sat.acc[0]); end
   endtask

   task automatic test_midop_load_reset();
      step(2'd3, 9'h000);
      step(2'd1, 9'd2);
      step(2'd2, 9'h000);
      step(2'd2, 9'h000);
      checks++; if (d2_result !== 9'd2 || d2_valid !== 1'b1) begin failures++; $display("FAIL midop_pre got=%h/%b exp=002/1", d2_result, d2_valid); end
      step(2'd1, 9'd7);
      checks++; if (d3_valid !== 1'b0 || dut3.fill_cnt !== 2'd0) begin failures++; $display("FAIL midop_load got=%b/%0d exp=0/0", d3_valid, dut3.fill_cnt); end
      checks++; if (d2_result !== 9'd2 || d2_valid !== 1'b0) begin failures++; $display("FAIL midop_partial got=%h/%b exp=002/0", d2_result, d2_valid); end
      rst = 1'b1;
      step(2'd2, 9'h1FF);
      checks++; if (d2_result !== 9'd0 || dut2.acc[0] !== 9'd0 || dut3.fill_cnt !== 2'd0 || d2_ovf !== 1'b0) begin failures++; $display("FAIL midop_reset got=%h/%h/%0d/%b exp=000/000/0/0", d2_result, dut2.acc[0], dut3.fill_cnt, d2_ovf); end
      rst = 1'b0;
      step(2'd2, 9'h1FF);
      checks++; if (d1_result !== 9'd0 || d1_valid !== 1'b1) begin failures++; $display("FAIL post_reset_word got=%h/%b exp=000/1", d1_result, d1_valid); end
   endtask

   initial begin
      rst    = 1'b0;
      func   = 2'd0;
      inWord = 9'd0;
      test_reset();
      test_fill();
      test_clear();
      test_overflow();
      test_midop_load_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
